fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO, the successor to the fixed 4-bit x 8 FIFO. It adds generic width and depth, a selectable read mode (standard registered or first-word-fall-through), an occupancy count, programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a synchronous flush. It is used as the general buffering element between producer and consumer logic in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of 2, >=2
FWFT, 0, read mode: 0 = standard (data appears 1 cycle after pop), 1 = first-word-fall-through
AF_THRESH, DEPTH-2, Almost_Full asserted when Count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, Almost_Empty asserted when Count <= AE_THRESH (0..DEPTH-1)

Ports:
CLK  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of contents, pointers and Count
push  in  1  write request
pop  in  1  read request
Data_In  in  WIDTH  write data
clr_err  in  1  clears Overflow and Underflow
Data_Out  out  WIDTH  read data
Data_Valid  out  1  Data_Out holds valid popped/head data
Full  out  1  Count == DEPTH
Empty  out  1  Count == 0
Almost_Full  out  1  Count >= AF_THRESH
Almost_Empty  out  1  Count <= AE_THRESH
Count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
Overflow  out  1  sticky: push was rejected
Underflow  out  1  sticky: pop was rejected

Behaviour:
- Reset (rst_n=0, asynchronous): pointers=0, Count=0, Data_Out=0, Data_Valid=0, Full=0, Empty=1, Almost_Empty=1, Almost_Full=0, Overflow=0, Underflow=0. Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count is a separate register.
- Flag outputs are registered and derived from the next value of Count, so they are exact in the cycle after the edge. There is no combinational path from push/pop to the flags.
- Pop accept: pop_ok = pop & !Empty. A pop on Empty is ignored and sets Underflow.
- Push accept: push_ok = push & (!Full | pop_ok). A push on Full with no accepted pop is ignored and sets Overflow.
- Push and pop together when Full: both accepted, Count unchanged.
- Push and pop together when Empty: push accepted, pop rejected, Underflow set. In FWFT mode the word is not bypassed.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged otherwise.
- Standard mode (FWFT=0): on pop_ok, Data_Out <= mem[rd_ptr] at the edge. Data_Valid pulses 1 cycle after each accepted pop and is 0 otherwise. Data_Out holds its last value while Data_Valid=0.
- FWFT mode (FWFT=1): Data_Out = mem[rd_ptr] whenever !Empty, and Data_Valid = !Empty (registered). A word pushed into an empty FIFO appears on Data_Out with Data_Valid=1 one cycle after the push edge. pop consumes the displayed word.
- flush=1: next edge sets pointers=0 and Count=0, Empty=1, Data_Valid=0. flush takes priority over push and pop in the same cycle; those requests are dropped and flag no errors. Overflow and Underflow are unaffected by flush.
- Error flags: set on a rejected request and held until clr_err or reset. If clr_err and a new error occur in the same cycle, the flag stays set.
- Reset mid-operation: all state returns to reset values immediately. Data in flight is lost.
- Elaboration check: a non-power-of-2 DEPTH or out-of-range thresholds cause $fatal.

Decomposition:
- Package fifo_pkg holds:
  - mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1
  - a clog2 helper
  - the default threshold constants
- Sub-module fifo_mem_dp(WIDTH, DEPTH): simple dual-port array with synchronous write and asynchronous read, indexed by write and read pointers. All control logic (pointers, Count, flags, mode mux) stays in fifo_sync_param.

Test Plan:
1. Defaults, FWFT=0: push 0x01..0x10 on 16 consecutive cycles -> Count=16, Full=1 and Almost_Full=1 (from Count 14); Almost_Empty clears at Count 3. Pop 16 times -> Data_Out 0x01..0x10 in order, each with a 1-cycle Data_Valid pulse, Empty=1 at the end.
2. Full FIFO: push 0xAA alone -> Overflow=1, Count stays 16. Push 0xAA with pop -> head word out, 0xAA stored, Count=16, no new error. clr_err -> Overflow=0.
3. Empty FIFO: pop -> Underflow=1, Data_Valid stays 0. Push 0x5C with pop on empty -> Count=1, Underflow stays 1.
4. FWFT=1: push 0x3E into empty -> next cycle Data_Out=0x3E and Data_Valid=1 with no pop. Pop -> Empty=1 and Data_Valid=0 the following cycle.
5. Wrap-around: run 40 push/pop pairs at Count~5 -> pointers wrap twice, data order preserved, Count constant at 5.
6. Flush with push=1 at Count=9 -> Count=0, Empty=1, no Overflow. Asserting rst_n=0 mid-burst -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the parametrised synchronous FIFO.
package fifo_pkg;
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;
    localparam int DEF_AF_MARGIN  = 2;
    localparam int DEF_AE_THRESH  = 2;

    function automatic int fifo_clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: dual-port storage array, synchronous write and asynchronous read.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
)(
    input  logic                          CLK,
    input  logic                          we,
    input  logic [fifo_clog2(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]              wdata,
    input  logic [fifo_clog2(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]              rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge CLK)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with selectable read mode, occupancy count,
// programmable almost flags, sticky error flags and synchronous flush.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = FIFO_MODE_STD,
    parameter int AF_THRESH = DEPTH - DEF_AF_MARGIN,
    parameter int AE_THRESH = DEF_AE_THRESH
)(
    input  logic                        CLK,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            Data_In,
    input  logic                        clr_err,
    output logic [WIDTH-1:0]            Data_Out,
    output logic                        Data_Valid,
    output logic                        Full,
    output logic                        Empty,
    output logic                        Almost_Full,
    output logic                        Almost_Empty,
    output logic [fifo_clog2(DEPTH):0]  Count,
    output logic                        Overflow,
    output logic                        Underflow
);
    localparam int AW = fifo_clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $fatal(1, "fifo_sync_param: DEPTH must be a power of 2 and >= 2");
    end
    if (WIDTH < 1) begin : g_chk_width
        $fatal(1, "fifo_sync_param: WIDTH must be >= 1");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_chk_af
        $fatal(1, "fifo_sync_param: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_chk_ae
        $fatal(1, "fifo_sync_param: AE_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_chk_mode
        $fatal(1, "fifo_sync_param: FWFT must be 0 or 1");
    end

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] rd_data, dout_r;
    logic             valid_r, pop_ok, push_ok, pop_err, push_err;

    // Flush swallows same-cycle requests, so they neither move data nor raise errors.
    always_comb begin
        pop_ok    = pop & ~Empty & ~flush;
        push_ok   = push & (~Full | pop_ok) & ~flush;
        pop_err   = pop & Empty & ~flush;
        push_err  = push & Full & ~pop_ok & ~flush;
        count_nxt = flush ? '0 : Count + CW'(push_ok) - CW'(pop_ok);
    end

    fifo_mem_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .CLK   (CLK),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (Data_In),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            Count        <= '0;
            Full         <= 1'b0;
            Empty        <= 1'b1;
            Almost_Full  <= 1'b0;
            Almost_Empty <= 1'b1;
            Overflow     <= 1'b0;
            Underflow    <= 1'b0;
            dout_r       <= '0;
            valid_r      <= 1'b0;
        end else begin
            wr_ptr       <= flush ? '0 : wr_ptr + AW'(push_ok);
            rd_ptr       <= flush ? '0 : rd_ptr + AW'(pop_ok);
            Count        <= count_nxt;
            Full         <= count_nxt == CW'(DEPTH);
            Empty        <= count_nxt == '0;
            Almost_Full  <= count_nxt >= CW'(AF_THRESH);
            Almost_Empty <= count_nxt <= CW'(AE_THRESH);
            Overflow     <= push_err | (Overflow & ~clr_err);
            Underflow    <= pop_err | (Underflow & ~clr_err);
            dout_r       <= pop_ok ? rd_data : dout_r;
            valid_r      <= (FWFT == FIFO_MODE_FWFT) ? (count_nxt != '0) : pop_ok;
        end
    end

    // FWFT shows the head word directly; zero while empty keeps the reset value visible.
    assign Data_Out   = (FWFT == FIFO_MODE_FWFT) ? (valid_r ? rd_data : '0) : dout_r;
    assign Data_Valid = valid_r;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed stimulus for standard and FWFT instances; a negedge
// monitor checks every Data_Valid word of the standard instance against a queue.
module tb_fifo_sync_param;
    localparam int W = 8;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         s_flush = 0, s_push = 0, s_pop = 0, s_clr = 0;
    logic [W-1:0] s_din = '0, s_dout;
    logic         s_dv, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [4:0]   s_cnt;

    logic         f_flush = 0, f_push = 0, f_pop = 0, f_clr = 0;
    logic [W-1:0] f_din = '0, f_dout;
    logic         f_dv, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0]   f_cnt;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e_mon;

    fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
        .CLK(clk), .rst_n(rst_n), .flush(s_flush), .push(s_push), .pop(s_pop),
        .Data_In(s_din), .clr_err(s_clr), .Data_Out(s_dout), .Data_Valid(s_dv),
        .Full(s_full), .Empty(s_empty), .Almost_Full(s_af), .Almost_Empty(s_ae),
        .Count(s_cnt), .Overflow(s_ovf), .Underflow(s_udf)
    );

    fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fw (
        .CLK(clk), .rst_n(rst_n), .flush(f_flush), .push(f_push), .pop(f_pop),
        .Data_In(f_din), .clr_err(f_clr), .Data_Out(f_dout), .Data_Valid(f_dv),
        .Full(f_full), .Empty(f_empty), .Almost_Full(f_af), .Almost_Empty(f_ae),
        .Count(f_cnt), .Overflow(f_ovf), .Underflow(f_udf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && s_dv) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL std_dout: got %0h with no word expected", s_dout);
            end else begin
                e_mon = exp_q.pop_front();
                if (s_dout !== e_mon) begin
                    fails++;
                    $display("FAIL std_dout: got %0h, expected %0h", s_dout, e_mon);
                end
            end
        end
    end

    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst_cnt", s_cnt, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_full", s_full, 0);
        chk("rst_af", s_af, 0);
        chk("rst_ae", s_ae, 1);
        chk("rst_dv", s_dv, 0);
        chk("rst_dout", s_dout, 0);
        chk("rst_ovf", s_ovf, 0);
        chk("rst_udf", s_udf, 0);
        chk("rst_fw_dv", f_dv, 0);
        chk("rst_fw_dout", f_dout, 0);
        chk("rst_fw_empty", f_empty, 1);
        #10 rst_n = 1;
        cyc();

        // fill to full, then drain in order
        for (int i = 1; i <= 16; i++) begin
            s_push = 1; s_din = W'(i);
            cyc();
            chk("fill_cnt", s_cnt, i);
            chk("fill_af", s_af, (i >= 14) ? 1 : 0);
            chk("fill_ae", s_ae, (i <= 2) ? 1 : 0);
            chk("fill_full", s_full, (i == 16) ? 1 : 0);
        end
        s_push = 0;
        for (int i = 1; i <= 16; i++) begin
            s_pop = 1; exp_q.push_back(W'(i));
            cyc();
            chk("drain_cnt", s_cnt, 16 - i);
        end
        s_pop = 0;
        cyc();
        chk("drain_dv_off", s_dv, 0);
        chk("drain_empty", s_empty, 1);
        chk("drain_dout_hold", s_dout, 8'h10);

        // overflow and push+pop on full
        for (int i = 1; i <= 16; i++) begin
            s_push = 1; s_din = W'(8'h40 + i);
            cyc();
        end
        chk("ovf_pre_full", s_full, 1);
        s_din = 8'hAA;
        cyc();
        chk("ovf_set", s_ovf, 1);
        chk("ovf_cnt", s_cnt, 16);
        s_pop = 1; exp_q.push_back(8'h41);
        cyc();
        chk("full_pp_cnt", s_cnt, 16);
        chk("full_pp_full", s_full, 1);
        chk("full_pp_ovf", s_ovf, 1);
        s_push = 0; s_pop = 0; s_clr = 1;
        cyc();
        chk("ovf_clr", s_ovf, 0);
        s_clr = 0;
        for (int i = 2; i <= 17; i++) begin
            s_pop = 1; exp_q.push_back((i == 17) ? 8'hAA : W'(8'h40 + i));
            cyc();
        end
        s_pop = 0;
        cyc();
        chk("ovf_drain_empty", s_empty, 1);
        chk("ovf_still_clr", s_ovf, 0);
        chk("no_udf", s_udf, 0);

        // underflow and push+pop on empty
        s_pop = 1;
        cyc();
        chk("udf_set", s_udf, 1);
        chk("udf_cnt", s_cnt, 0);
        chk("udf_dv", s_dv, 0);
        s_push = 1; s_din = 8'h5C;
        cyc();
        chk("empty_pp_cnt", s_cnt, 1);
        chk("empty_pp_udf", s_udf, 1);
        chk("empty_pp_dv", s_dv, 0);
        s_push = 0; exp_q.push_back(8'h5C);
        cyc();
        chk("udf_pop_cnt", s_cnt, 0);
        s_pop = 0; s_clr = 1;
        cyc();
        chk("udf_clr", s_udf, 0);
        s_clr = 0;

        // wrap-around at constant occupancy
        for (int k = 0; k < 5; k++) begin
            s_push = 1; s_din = W'(8'h60 + k);
            cyc();
        end
        for (int k = 0; k < 40; k++) begin
            s_push = 1; s_pop = 1; s_din = W'(8'h65 + k); exp_q.push_back(W'(8'h60 + k));
            cyc();
            chk("wrap_cnt", s_cnt, 5);
        end
        s_push = 0;
        for (int k = 40; k < 45; k++) begin
            s_pop = 1; exp_q.push_back(W'(8'h60 + k));
            cyc();
        end
        s_pop = 0;
        cyc();
        chk("wrap_empty", s_empty, 1);

        // flush beats a same-cycle push
        for (int k = 0; k < 9; k++) begin
            s_push = 1; s_din = W'(8'h90 + k);
            cyc();
        end
        chk("pre_flush_cnt", s_cnt, 9);
        s_flush = 1; s_din = 8'hEE;
        cyc();
        chk("flush_cnt", s_cnt, 0);
        chk("flush_empty", s_empty, 1);
        chk("flush_ovf", s_ovf, 0);
        chk("flush_ae", s_ae, 1);
        chk("flush_dv", s_dv, 0);
        s_flush = 0; s_din = 8'h77;
        cyc();
        s_push = 0; s_pop = 1; exp_q.push_back(8'h77);
        cyc();
        s_pop = 0;
        cyc();
        chk("post_flush_empty", s_empty, 1);

        // asynchronous reset mid-burst
        for (int k = 0; k < 3; k++) begin
            s_push = 1; s_din = W'(8'hB0 + k);
            cyc();
        end
        s_din = 8'hB3; s_pop = 1; exp_q.push_back(8'hB0);
        cyc();
        chk("burst_dv", s_dv, 1);
        chk("burst_cnt", s_cnt, 3);
        s_push = 0; s_pop = 0;
        #6 rst_n = 0;
        #1;
        chk("arst_cnt", s_cnt, 0);
        chk("arst_empty", s_empty, 1);
        chk("arst_dv", s_dv, 0);
        chk("arst_dout", s_dout, 0);
        chk("arst_ae", s_ae, 1);
        chk("arst_af", s_af, 0);
        #5 rst_n = 1;
        cyc();

        // first-word-fall-through instance
        f_push = 1; f_din = 8'h3E;
        cyc();
        f_push = 0;
        chk("fw_dv", f_dv, 1);
        chk("fw_dout", f_dout, 8'h3E);
        chk("fw_cnt", f_cnt, 1);
        cyc();
        chk("fw_hold", f_dout, 8'h3E);
        f_pop = 1;
        cyc();
        f_pop = 0;
        chk("fw_pop_empty", f_empty, 1);
        chk("fw_pop_dv", f_dv, 0);
        f_push = 1; f_pop = 1; f_din = 8'h11;
        cyc();
        chk("fw_pp_cnt", f_cnt, 1);
        chk("fw_pp_udf", f_udf, 1);
        chk("fw_pp_dout", f_dout, 8'h11);
        f_pop = 0; f_din = 8'h22;
        cyc();
        f_push = 0;
        chk("fw_head", f_dout, 8'h11);
        chk("fw_cnt2", f_cnt, 2);
        f_pop = 1;
        cyc();
        f_pop = 0;
        chk("fw_next", f_dout, 8'h22);
        chk("fw_cnt3", f_cnt, 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
